// File: rtl/hs32_pkg.sv
// hs32_pkg: definitions shared by the HS32 fetch path.
//   HS32_XLEN       - datapath / address width in bits
//   HS32_INSN_BYTES - byte distance between consecutive instructions
//   hs32_fetch_t    - one buffered fetch result: instruction word plus its PC
package hs32_pkg;

    localparam int HS32_XLEN       = 32;
    localparam int HS32_INSN_BYTES = 4;

    typedef struct packed {
        logic [HS32_XLEN-1:0] insn;
        logic [HS32_XLEN-1:0] pc;
    } hs32_fetch_t;

endpackage

// File: rtl/hs32_sync_fifo.sv
// hs32_sync_fifo: width-parametrised synchronous FIFO with a fill count.
//   clk        - clock, all updates on the rising edge
//   reset      - asynchronous, active-low; empties the FIFO
//   clear      - synchronous empty; wins over push and pop in the same cycle
//   push       - write push_data at the tail (ignored when full)
//   push_data  - entry to write
//   pop        - drop the head entry (ignored when empty)
//   head       - current head entry, valid while fill > 0
//   fill       - number of stored entries, 0 .. 2**DEPTH_LOG2
module hs32_sync_fifo #(
    parameter int WIDTH      = 64,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  push,
    input  logic [WIDTH-1:0]      push_data,
    input  logic                  pop,
    output logic [WIDTH-1:0]      head,
    output logic [DEPTH_LOG2:0]   fill
);

    localparam int DEPTH = 2**DEPTH_LOG2;
    localparam int PTR_W = DEPTH_LOG2 + 1;

    // Pointers carry one extra wrap bit so that full and empty are
    // distinguishable without a separate counter.
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             full;
    logic             empty;
    logic             do_push;
    logic             do_pop;

    // Full when the wrap bits differ but the index bits match.
    always_comb begin
        full    = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                  (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
        empty   = (wr_ptr == rd_ptr);
        do_push = push && !full && !clear;
        do_pop  = pop && !empty && !clear;
        fill    = wr_ptr - rd_ptr;
        head    = mem[rd_ptr[DEPTH_LOG2-1:0]];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        end
    end

    // Storage needs no reset: entries are only observed after a push.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[DEPTH_LOG2-1:0]] <= push_data;
    end

endmodule

// File: rtl/hs32_prefetch.sv
// hs32_prefetch: pipelined HS32 instruction prefetcher.
// Keeps up to MAX_OUT memory requests in flight and buffers returned
// instructions with their PCs for decode. A flush redirects fetch and
// silently discards responses still owed to the old stream.
//   clk, reset       - clock and asynchronous active-low reset
//   addr, stbm       - registered request address and strobe to the arbiter
//   dtr, ackm        - in-order response data and valid
//   stlm             - arbiter rejects the request strobed this cycle
//   instd, pcd, reqd - head instruction, its PC, and valid toward decode
//   rdyd             - decode takes the head
//   newpc, flush     - redirect target and redirect/discard command
module hs32_prefetch
    import hs32_pkg::*;
#(
    parameter int                   DEPTH_LOG2 = 2,
    parameter int                   MAX_OUT    = 2,
    parameter int                   LOW_WATER  = (2**DEPTH_LOG2) / 2,
    parameter logic [HS32_XLEN-1:0] RESET_PC   = 32'h0
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic [HS32_XLEN-1:0] addr,
    output logic                 stbm,
    input  logic [HS32_XLEN-1:0] dtr,
    input  logic                 ackm,
    input  logic                 stlm,
    output logic [HS32_XLEN-1:0] instd,
    output logic [HS32_XLEN-1:0] pcd,
    output logic                 reqd,
    input  logic                 rdyd,
    input  logic [HS32_XLEN-1:0] newpc,
    input  logic                 flush
);

    localparam int DEPTH  = 2**DEPTH_LOG2;
    localparam int CNT_W  = $clog2(MAX_OUT + 1);
    localparam int FILL_W = DEPTH_LOG2 + 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_REQ   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]            st;
    logic [1:0]            st_next;
    logic [CNT_W-1:0]      out_q;
    logic [CNT_W-1:0]      out_next;
    logic [CNT_W-1:0]      drop_q;
    logic [CNT_W-1:0]      drop_next;
    logic [HS32_XLEN-1:0]  rpc;
    logic                  refill;
    logic                  refill_next;
    logic [FILL_W-1:0]     fill;
    logic [FILL_W-1:0]     fill_next;
    logic [31:0]           inflight_next;
    logic [31:0]           credit_next;
    logic                  accept;
    logic                  ack_valid;
    logic                  ack_drop;
    logic                  ack_push;
    logic                  push;
    logic                  pop;
    logic                  issue;
    hs32_fetch_t           push_entry;
    hs32_fetch_t           head;

    // The strobe is a decode of the registered state, so it stays a clean
    // flop output and clears immediately on reset.
    assign stbm  = (st == ST_REQ);
    assign reqd  = !flush && (fill != '0) && !refill;
    assign instd = head.insn;
    assign pcd   = head.pc;

    // Request/response bookkeeping. An ack with nothing owed is ignored so a
    // misbehaving arbiter cannot underflow the counters. Drops are owed
    // before live responses because responses return in order.
    always_comb begin
        accept    = stbm && !stlm;
        ack_valid = ackm && ((32'(out_q) + 32'(drop_q)) != 32'd0);
        ack_drop  = ack_valid && (drop_q != '0);
        ack_push  = ack_valid && (drop_q == '0);
        push      = ack_push && !flush;
        pop       = rdyd && reqd;
        push_entry.insn = dtr;
        push_entry.pc   = rpc;
    end

    // Next-state counters. On flush everything still owed, including a
    // request accepted in the flush cycle itself, becomes a drop.
    always_comb begin
        out_next  = out_q;
        drop_next = drop_q;
        fill_next = fill;
        if (flush) begin
            out_next  = '0;
            drop_next = CNT_W'(32'(drop_q) + 32'(out_q) + 32'(accept) - 32'(ack_valid));
            fill_next = '0;
        end else begin
            out_next  = out_q + CNT_W'(accept) - CNT_W'(ack_push);
            drop_next = drop_q - CNT_W'(ack_drop);
            fill_next = fill + FILL_W'(push) - FILL_W'(pop);
        end
    end

    // Issue only while both the in-flight limit and FIFO credit allow it;
    // counting outstanding live requests against free space is what keeps
    // the FIFO from ever overflowing.
    always_comb begin
        inflight_next = 32'(out_next) + 32'(drop_next);
        credit_next   = 32'(fill_next) + 32'(out_next);
        issue         = !flush && (inflight_next < 32'(MAX_OUT)) && (credit_next < 32'(DEPTH));
        st_next       = ST_IDLE;
        if (flush)                  st_next = ST_DRAIN;
        else if (issue)             st_next = ST_REQ;
        else if (drop_next != '0)   st_next = ST_DRAIN;
        else                        st_next = ST_IDLE;
    end

    // Hysteresis: after the buffer runs dry (or is flushed) decode waits
    // until LOW_WATER entries are buffered, avoiding one-entry stutter.
    always_comb begin
        refill_next = refill;
        if (flush)                                refill_next = 1'b1;
        else if (fill_next == '0)                 refill_next = 1'b1;
        else if (32'(fill_next) >= 32'(LOW_WATER)) refill_next = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st     <= ST_IDLE;
            addr   <= RESET_PC;
            rpc    <= RESET_PC;
            out_q  <= '0;
            drop_q <= '0;
            refill <= 1'b1;
        end else begin
            st     <= st_next;
            out_q  <= out_next;
            drop_q <= drop_next;
            refill <= refill_next;
            if (flush) begin
                addr <= newpc;
                rpc  <= newpc;
            end else begin
                if (accept) addr <= addr + HS32_XLEN'(HS32_INSN_BYTES);
                if (push)   rpc  <= rpc + HS32_XLEN'(HS32_INSN_BYTES);
            end
        end
    end

    hs32_sync_fifo #(
        .WIDTH      ($bits(hs32_fetch_t)),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .clear     (flush),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head),
        .fill      (fill)
    );

`ifdef FORMAL
    // A response must always be owed to somebody.
    always @(posedge clk) begin
        if (reset) assert (!(ackm && (out_q == '0) && (drop_q == '0)));
    end
`endif

endmodule

// File: tb/tb_hs32_prefetch.sv
// tb_hs32_prefetch: directed bench for hs32_prefetch.
// A transaction-level model tracks owed responses (tagged with a flush
// epoch) and the expected decode queue; every cycle the DUT outputs are
// compared against it, and each scenario adds hand-computed literals.
module tb_hs32_prefetch;
    import hs32_pkg::*;

    localparam int          DEPTH_LOG2 = 2;
    localparam int          DEPTH      = 4;
    localparam int          MAX_OUT    = 2;
    localparam int          LOW_WATER  = 2;
    localparam logic [31:0] RESET_PC   = 32'h0;

    logic        clk;
    logic        reset;
    logic [31:0] addr;
    logic        stbm;
    logic [31:0] dtr;
    logic        ackm;
    logic        stlm;
    logic [31:0] instd;
    logic [31:0] pcd;
    logic        reqd;
    logic        rdyd;
    logic [31:0] newpc;
    logic        flush;

    hs32_prefetch #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .MAX_OUT    (MAX_OUT),
        .LOW_WATER  (LOW_WATER),
        .RESET_PC   (RESET_PC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .addr  (addr),
        .stbm  (stbm),
        .dtr   (dtr),
        .ackm  (ackm),
        .stlm  (stlm),
        .instd (instd),
        .pcd   (pcd),
        .reqd  (reqd),
        .rdyd  (rdyd),
        .newpc (newpc),
        .flush (flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Scenario controls
    logic        c_flush;
    logic [31:0] c_newpc;
    logic        c_rdyd;
    int          ack_budget;
    int          stall_left;
    logic [31:0] stall_addr;

    // Model state: owed responses with their epoch, expected decode queue
    logic [31:0] pend_addr[$];
    int          pend_epoch[$];
    int          epoch;
    logic [31:0] q_insn[$];
    logic [31:0] q_pc[$];
    logic [31:0] m_next_addr;
    logic        m_refill;

    // Logs for literal checks
    logic [31:0] acc_log[$];
    logic [31:0] pop_pc[$];
    logic [31:0] pop_insn[$];
    int          pop_cyc[$];
    int          cyc;
    int          reqd_seen;
    int          stall_strobes;
    int          dead_cnt;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, want %h", name, actual, expected);
        end
    endtask

    function automatic logic modelReqd();
        return !flush && (q_pc.size() > 0) && !m_refill;
    endfunction

    // Per-cycle comparison of the DUT against the model.
    task automatic compareModel();
        logic m_reqd;
        int   live_cnt;
        m_reqd   = modelReqd();
        live_cnt = 0;
        foreach (pend_epoch[i]) if (pend_epoch[i] == epoch) live_cnt++;
        checkOutput("reqd", 32'(reqd), 32'(m_reqd));
        if (stbm) checkOutput("stbm addr", addr, m_next_addr);
        if (m_reqd) begin
            checkOutput("instd", instd, q_insn[0]);
            checkOutput("pcd", pcd, q_pc[0]);
        end
        checkOutput("in-flight bound", 32'(pend_addr.size() <= MAX_OUT), 32'd1);
        checkOutput("credit bound", 32'((live_cnt + q_pc.size()) <= DEPTH), 32'd1);
    endtask

    // Advance the model by the events happening at the coming rising edge.
    task automatic updateModel();
        logic m_reqd;
        m_reqd = modelReqd();
        if (stbm && !stlm) begin
            pend_addr.push_back(m_next_addr);
            pend_epoch.push_back(epoch);
            acc_log.push_back(addr);
            m_next_addr = m_next_addr + 32'd4;
        end
        if (m_reqd && rdyd) begin
            pop_pc.push_back(pcd);
            pop_insn.push_back(instd);
            pop_cyc.push_back(cyc);
            void'(q_pc.pop_front());
            void'(q_insn.pop_front());
        end
        if (ackm && pend_addr.size() > 0) begin
            if (pend_epoch[0] == epoch && !flush) begin
                q_insn.push_back(dtr);
                q_pc.push_back(pend_addr[0]);
            end
            void'(pend_addr.pop_front());
            void'(pend_epoch.pop_front());
        end
        if (flush) begin
            q_pc.delete();
            q_insn.delete();
            epoch++;
            m_next_addr = newpc;
            m_refill    = 1'b1;
        end else if (q_pc.size() == 0) begin
            m_refill = 1'b1;
        end else if (q_pc.size() >= LOW_WATER) begin
            m_refill = 1'b0;
        end
    endtask

    // One clock cycle: drive inputs (including the in-order responder and
    // the stalling arbiter), then sample and compare, then advance the model.
    task automatic applyStimulus();
        @(negedge clk);
        cyc++;
        flush = c_flush;
        newpc = c_newpc;
        rdyd  = c_rdyd;
        stlm  = 1'b0;
        if (stall_left > 0 && stbm && addr == stall_addr) begin
            stlm = 1'b1;
            stall_left--;
        end
        ackm = 1'b0;
        dtr  = 32'h0;
        if (ack_budget != 0 && pend_addr.size() > 0) begin
            ackm = 1'b1;
            dtr  = (pend_epoch[0] == epoch) ? pend_addr[0] : 32'hDEAD;
            if (ack_budget > 0) ack_budget--;
        end
        #1;
        if (stbm && addr == stall_addr) stall_strobes++;
        if (reqd) reqd_seen++;
        compareModel();
        updateModel();
    endtask

    task automatic runCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus();
    endtask

    // Asynchronous reset between scenarios; the arbiter model resets too.
    task automatic doReset();
        @(negedge clk);
        #2;
        reset = 1'b0;
        flush = 1'b0; newpc = 32'h0; rdyd = 1'b0; stlm = 1'b0; ackm = 1'b0; dtr = 32'h0;
        c_flush = 1'b0; c_newpc = 32'h0; c_rdyd = 1'b0;
        ack_budget = -1; stall_left = 0; stall_addr = 32'hFFFF_FFFF;
        #1;
        checkOutput("reset stbm", 32'(stbm), 32'd0);
        checkOutput("reset reqd", 32'(reqd), 32'd0);
        checkOutput("reset addr", addr, RESET_PC);
        pend_addr.delete(); pend_epoch.delete();
        q_pc.delete(); q_insn.delete();
        acc_log.delete(); pop_pc.delete(); pop_insn.delete(); pop_cyc.delete();
        epoch++;
        m_next_addr = RESET_PC;
        m_refill    = 1'b1;
        cyc = 0; reqd_seen = 0; stall_strobes = 0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        flush = 1'b0; newpc = 32'h0; rdyd = 1'b0; stlm = 1'b0; ackm = 1'b0; dtr = 32'h0;
        epoch = 0;

        // Reset and streaming: first strobe one edge after release.
        doReset();
        c_rdyd = 1'b1;
        #1;
        checkOutput("stbm before first edge", 32'(stbm), 32'd0);
        applyStimulus();
        checkOutput("first stbm", 32'(stbm), 32'd1);
        checkOutput("first addr", addr, 32'h0);
        runCycles(13);
        checkOutput("stream pop count", 32'(pop_pc.size() >= 8), 32'd1);
        for (int i = 0; i < 8 && i < pop_pc.size(); i++) begin
            checkOutput("stream pcd", pop_pc[i], 32'(4 * i));
            checkOutput("stream instd", pop_insn[i], 32'(4 * i));
            checkOutput("stream one per cycle", 32'(pop_cyc[i] - pop_cyc[0]), 32'(i));
        end

        // Stall the request at 0x8 for three cycles.
        doReset();
        c_rdyd = 1'b1; stall_addr = 32'h8; stall_left = 3;
        runCycles(22);
        checkOutput("stall strobes at 0x8", 32'(stall_strobes), 32'd4);
        checkOutput("stall pop count", 32'(pop_pc.size() >= 6), 32'd1);
        for (int i = 0; i < 6 && i < pop_pc.size(); i++)
            checkOutput("stall order", pop_pc[i], 32'(4 * i));

        // Credit: decode blocked, exactly DEPTH requests, then one per pop.
        doReset();
        runCycles(10);
        checkOutput("credit accepted", 32'(acc_log.size()), 32'd4);
        checkOutput("credit stbm idle", 32'(stbm), 32'd0);
        checkOutput("credit reqd", 32'(reqd), 32'd1);
        checkOutput("credit model fill", 32'(q_pc.size()), 32'd4);
        c_rdyd = 1'b1;
        applyStimulus();
        c_rdyd = 1'b0;
        runCycles(6);
        checkOutput("credit accepted after pop", 32'(acc_log.size()), 32'd5);
        if (acc_log.size() >= 5) checkOutput("credit new addr", acc_log[4], 32'h10);

        // Flush with two requests in flight; their responses carry 0xDEAD.
        doReset();
        c_rdyd = 1'b1; ack_budget = 0;
        runCycles(3);
        checkOutput("flush in flight", 32'(acc_log.size()), 32'd2);
        c_flush = 1'b1; c_newpc = 32'h100;
        applyStimulus();
        c_flush = 1'b0; ack_budget = -1;
        runCycles(10);
        checkOutput("flush accepted count", 32'(acc_log.size() >= 3), 32'd1);
        if (acc_log.size() >= 3) checkOutput("flush next addr", acc_log[2], 32'h100);
        checkOutput("flush pop count", 32'(pop_pc.size() >= 1), 32'd1);
        if (pop_pc.size() >= 1) begin
            checkOutput("flush first pcd", pop_pc[0], 32'h100);
            checkOutput("flush first instd", pop_insn[0], 32'h100);
        end
        dead_cnt = 0;
        foreach (pop_insn[i]) if (pop_insn[i] == 32'hDEAD) dead_cnt++;
        checkOutput("flush discarded", 32'(dead_cnt), 32'd0);

        // Hysteresis: one buffered entry is not offered to decode.
        doReset();
        c_rdyd = 1'b1; ack_budget = 1;
        runCycles(6);
        checkOutput("hyst reqd held low", 32'(reqd_seen), 32'd0);
        ack_budget = 1;
        applyStimulus();
        checkOutput("hyst reqd during 2nd ack", 32'(reqd), 32'd0);
        applyStimulus();
        checkOutput("hyst reqd after 2nd push", 32'(reqd), 32'd1);
        checkOutput("hyst pcd", pcd, 32'h0);

        // PC wrap after a redirect, then asynchronous reset mid-burst.
        doReset();
        c_rdyd = 1'b1; c_flush = 1'b1; c_newpc = 32'hFFFF_FFF8;
        applyStimulus();
        c_flush = 1'b0;
        runCycles(10);
        checkOutput("wrap pop count", 32'(pop_pc.size() >= 3), 32'd1);
        if (pop_pc.size() >= 3) begin
            checkOutput("wrap pcd 0", pop_pc[0], 32'hFFFF_FFF8);
            checkOutput("wrap pcd 1", pop_pc[1], 32'hFFFF_FFFC);
            checkOutput("wrap pcd 2", pop_pc[2], 32'h0);
        end
        @(negedge clk);
        #2;
        checkOutput("burst stbm before reset", 32'(stbm), 32'd1);
        checkOutput("burst reqd before reset", 32'(reqd), 32'd1);
        reset = 1'b0;
        #1;
        checkOutput("async reset stbm", 32'(stbm), 32'd0);
        checkOutput("async reset reqd", 32'(reqd), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
